// File: rtl/jpeg_pkg.sv
// Shared JPEG block geometry, sample types and elaboration helpers.
package jpeg_pkg;

   localparam int BLK_DIM    = 8;
   localparam int BLK_PIX    = BLK_DIM * BLK_DIM;
   localparam int JPEG_PIX_W = 8;

   typedef logic [JPEG_PIX_W-1:0]         pix_t;
   typedef pix_t [BLK_DIM-1:0][BLK_DIM-1:0] block_t;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   // A one-slot FIFO still needs a 1-bit pointer to keep the vectors legal.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/blk_fifo_ctrl.sv
// Pointer, occupancy and drop accounting for the whole-block FIFO.
module blk_fifo_ctrl
   import jpeg_pkg::*;
#(
   parameter  int DEPTH    = 2,
   parameter  int CNT_W    = 16,
   localparam int PTR_W    = ptr_width(DEPTH),
   localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid_in,
   input  logic             rd_done,
   output logic             in_ready,
   output logic             not_empty,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] drop_cnt
);

   logic [CNT_BITS-1:0] count;
   logic                drop;
   logic                rd_en;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full is judged on the registered count, so a slot freed this cycle is not reused.
   assign in_ready  = (count != CNT_BITS'(DEPTH));
   assign not_empty = (count != '0);
   assign wr_en     = valid_in & in_ready & ~flush;
   assign drop      = valid_in & ~in_ready & ~flush;
   assign rd_en     = rd_done & ~flush;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= bump(wr_ptr);
         if (rd_en) rd_ptr <= bump(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/block_pixel_streamer.sv
// Buffers whole 8x8 colour blocks and replays them as a row-major,
// LANES-wide pixel stream under valid/ready flow control.
module block_pixel_streamer
   import jpeg_pkg::*;
#(
   parameter int NCH   = 3,
   parameter int PIX_W = 8,
   parameter int LANES = 1,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [NCH-1:0][BLK_DIM-1:0][BLK_DIM-1:0][PIX_W-1:0] blk_in,
   input  logic                                                valid_in,
   output logic                                                in_ready,
   input  logic                                                flush,
   output logic [LANES-1:0][NCH-1:0][PIX_W-1:0]                pix_out,
   output logic                                                pix_valid,
   input  logic                                                pix_ready,
   output logic [2:0]                                          pix_row,
   output logic [2:0]                                          pix_col,
   output logic                                                blk_last,
   output logic [CNT_W-1:0]                                    blk_idx,
   output logic [CNT_W-1:0]                                    drop_cnt
);

   localparam int         PTR_W    = ptr_width(DEPTH);
   localparam logic [2:0] LAST_COL = 3'(BLK_DIM - LANES);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("block_pixel_streamer: LANES must be 1, 2, 4 or 8");
   end
   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("block_pixel_streamer: DEPTH must be a power of two");
   end

   typedef logic [NCH-1:0][BLK_DIM-1:0][BLK_DIM-1:0][PIX_W-1:0] slot_t;

   slot_t            mem [DEPTH];
   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [2:0]       row;
   logic [2:0]       col;
   logic             xfer;
   logic             last_xfer;

   blk_fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .valid_in (valid_in),
      .rd_done  (last_xfer),
      .in_ready (in_ready),
      .not_empty(pix_valid),
      .wr_en    (wr_en),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .drop_cnt (drop_cnt)
   );

   assign xfer      = pix_valid & pix_ready;
   assign last_xfer = xfer & blk_last;

   // NOTE: block storage has no reset; a slot is only read once count says it holds data.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= blk_in;
   end

   // col holds the pixel column of lane 0, so it steps by LANES and wraps into the next row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row     <= '0;
         col     <= '0;
         blk_idx <= '0;
      end else if (flush) begin
         row <= '0;
         col <= '0;
      end else if (xfer) begin
         if (col == LAST_COL) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 3'(LANES);
         end
         if (blk_last) blk_idx <= blk_idx + 1'b1;
      end
   end

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      pix_out  = '0;
      blk_last = 1'b0;
      if (pix_valid) begin
         for (int k = 0; k < LANES; k++) begin
            for (int ch = 0; ch < NCH; ch++) begin
               pix_out[k][ch] = mem[rd_ptr][ch][row][col + 3'(k)];
            end
         end
         blk_last = (row == 3'd7) && (col == LAST_COL);
      end
   end

   assign pix_row = row;
   assign pix_col = col;

endmodule
